// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory stage: access sizes, sweep FSM states
// and the alignment rule used by both the store path and the error logger.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Reserved size 2'b11 follows the word rule.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr[0];
      default:   return (addr != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_align_extend.sv
// Selects the addressed byte/half lane of a memory word and sign/zero-extends it.
// Purely combinational, zero latency; no flow control.
module load_align_extend
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        sext,
  output logic [31:0] value
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    case (addr)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = addr[1] ? word[31:16] : word[15:0];

    case (size)
      SIZE_BYTE: value = {{24{sext & b[7]}}, b};
      SIZE_HALF: value = {{16{sext & h[15]}}, h};
      default:   value = word;
    endcase
  end

endmodule

// File: rtl/data_memory_unit.sv
// Byte-addressed data memory with sub-word stores/loads and sticky misalignment logging.
// Loads are zero-latency, stores land at the posedge; all accesses are dropped until the zero-fill sweep completes.
module data_memory_unit
  import mem_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        MisalignErr,
  output logic [31:0] ErrAddr
);

  logic [31:0]       mem [DEPTH];
  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       rd_word;
  logic [31:0]       ld_val;
  logic [31:0]       wmask;
  logic [31:0]       wdata_rep;
  logic [31:0]       merged;
  logic              mis;
  logic              do_store;
  logic              log_err;

  // Upper address bits are dropped on purpose so addresses alias modulo DEPTH*4.
  assign idx      = ALUResult[ADDR_W+1:2];
  assign rd_word  = mem[idx];
  assign mis      = misaligned(MemSize, ALUResult[1:0]);
  assign Ready    = (state == ST_READY);
  assign do_store = Ready & MemWrite & ~mis;
  assign log_err  = Ready & (MemRead | MemWrite) & mis & ~MisalignErr;

  load_align_extend u_load (
    .word  (rd_word),
    .addr  (ALUResult[1:0]),
    .size  (MemSize),
    .sext  (MemSigned),
    .value (ld_val)
  );

  assign ReadData = (Ready & MemRead & ~mis) ? ld_val : 32'h0;

  // Replicate the sub-word across all lanes, then let the mask pick the addressed lane.
  always_comb begin
    case (MemSize)
      SIZE_BYTE: begin
        wmask     = 32'h0000_00FF << {ALUResult[1:0], 3'b000};
        wdata_rep = {4{WriteData[7:0]}};
      end
      SIZE_HALF: begin
        wmask     = ALUResult[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        wdata_rep = {2{WriteData[15:0]}};
      end
      default: begin
        wmask     = 32'hFFFF_FFFF;
        wdata_rep = WriteData;
      end
    endcase
  end

  assign merged = (rd_word & ~wmask) | (wdata_rep & wmask);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_CLEAR;
      ptr         <= '0;
      MisalignErr <= 1'b0;
      ErrAddr     <= 32'h0;
    end else begin
      if (state == ST_CLEAR) begin
        ptr <= ptr + 1'b1;
        if (ptr == ADDR_W'(DEPTH - 1)) state <= ST_READY;
      end
      if (log_err) begin
        MisalignErr <= 1'b1;
        ErrAddr     <= ALUResult;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_CLEAR)
        mem[ptr] <= 32'h0;
      else if (do_store)
        mem[idx] <= merged;
    end
  end

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed and randomized checks of data_memory_unit against a byte-array reference model.
module tb_data_memory_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ALUResult = '0;
  logic [31:0] WriteData = '0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [1:0]  MemSize = 2'b10;
  logic        MemSigned = 1'b0;
  logic [31:0] ReadData;
  logic        Ready;
  logic        MisalignErr;
  logic [31:0] ErrAddr;

  data_memory_unit dut (
    .clk         (clk),
    .rst         (rst),
    .ALUResult   (ALUResult),
    .WriteData   (WriteData),
    .MemWrite    (MemWrite),
    .MemRead     (MemRead),
    .MemSize     (MemSize),
    .MemSigned   (MemSigned),
    .ReadData    (ReadData),
    .Ready       (Ready),
    .MisalignErr (MisalignErr),
    .ErrAddr     (ErrAddr)
  );

  always #5 clk = ~clk;

  // Reference model: 256 bytes of little-endian memory plus ready/error state.
  logic [7:0]  mbytes [256];
  bit          mready;
  bit          merr;
  logic [31:0] merraddr;
  int          n_asserts = 0;
  int          n_fail = 0;
  logic [31:0] obs;

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit mmis(input logic [1:0] sz, input logic [31:0] ad);
    return (nbytes(sz) > 1) && ((ad % nbytes(sz)) != 0);
  endfunction

  function automatic logic [31:0] mload(input logic [31:0] ad, input logic [1:0] sz, input bit sg);
    int n = nbytes(sz);
    longint v = 0;
    for (int i = 0; i < n; i++) v += longint'(mbytes[(ad + i) % 256]) << (8 * i);
    if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_asserts++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, o, e);
    end
  endtask

  task automatic check_err(input string tag);
    check({tag, " err"}, {31'h0, MisalignErr}, {31'h0, merr});
    check({tag, " erraddr"}, ErrAddr, merraddr);
  endtask

  // One access cycle: compare the combinational load, then advance the model past the edge.
  task automatic acc(input bit wr, input bit rd, input logic [1:0] sz, input bit sg,
                     input logic [31:0] ad, input logic [31:0] wd, input string tag,
                     output logic [31:0] o);
    bit m;
    logic [31:0] e;
    MemWrite = wr; MemRead = rd; MemSize = sz; MemSigned = sg; ALUResult = ad; WriteData = wd;
    #1;
    m = mmis(sz, ad);
    e = (mready && rd && !m) ? mload(ad, sz, sg) : 32'h0;
    o = ReadData;
    check(tag, ReadData, e);
    tick();
    if (mready && (wr || rd) && m && !merr) begin
      merr = 1'b1;
      merraddr = ad;
    end
    if (mready && wr && !m)
      for (int i = 0; i < nbytes(sz); i++) mbytes[(ad + i) % 256] = 8'(wd >> (8 * i));
    MemWrite = 1'b0;
    MemRead = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) mbytes[i] = 8'h00;
    mready = 1'b0;
    merr = 1'b0;
    merraddr = 32'h0;
  endtask

  // Ready must stay low for exactly 64 cycles after release; optionally poke accesses mid-sweep.
  task automatic sweep_check(input string tag, input bit inject);
    logic [31:0] o;
    for (int c = 0; c < 64; c++) begin
      check($sformatf("%s ready_low c%0d", tag, c), {31'h0, Ready}, 32'h0);
      if (inject && c == 10)
        acc(1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'hCAFE_F00D, {tag, " sw_during_sweep"}, o);
      else if (inject && c == 20)
        acc(1'b0, 1'b1, 2'd2, 1'b0, 32'h3, 32'h0, {tag, " mis_lw_during_sweep"}, o);
      else
        tick();
    end
    check({tag, " ready_high"}, {31'h0, Ready}, 32'h1);
    mready = 1'b1;
  endtask

  initial begin
    logic [31:0] o;
    bit          wr, rd, sg;
    logic [1:0]  sz;
    logic [31:0] ad;

    // Initial bring-up, then fill the array with garbage and log an error.
    tick();
    do_reset();
    check("reset readdata", ReadData, 32'h0);
    check_err("reset");
    sweep_check("init", 1'b0);
    for (int w = 0; w < 64; w++)
      acc(1'b1, 1'b0, 2'd2, 1'b0, 32'(w * 4), $urandom, "garbage", o);
    acc(1'b1, 1'b0, 2'd2, 1'b0, 32'h5, 32'h0, "pre mis", o);
    check_err("pre");

    // T1: reset clears error and sweeps; reassert mid-sweep restarts; T6 accesses during sweep.
    do_reset();
    check_err("T1 after rst");
    for (int c = 0; c < 30; c++) tick();
    check("T1 mid ready", {31'h0, Ready}, 32'h0);
    do_reset();
    sweep_check("T1 restart", 1'b1);
    for (int w = 0; w < 64; w++)
      acc(1'b0, 1'b1, 2'd2, 1'b0, 32'(w * 4), 32'h0, $sformatf("T1 word%0d", w), o);
    check_err("T6");

    // T2: word store/load and aliasing.
    acc(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, "T2 sw", o);
    acc(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'h0, "T2 lw", o);
    check("T2 lw const", o, 32'hDEAD_BEEF);
    acc(1'b0, 1'b1, 2'd2, 1'b0, 32'h110, 32'h0, "T2 alias", o);
    check("T2 alias const", o, 32'hDEAD_BEEF);
    check_err("T2");

    // T3: sub-word lanes and extension.
    acc(1'b1, 1'b0, 2'd0, 1'b0, 32'h21, 32'h0000_0080, "T3 sb", o);
    acc(1'b0, 1'b1, 2'd0, 1'b0, 32'h21, 32'h0, "T3 lbu", o);
    check("T3 lbu const", o, 32'h0000_0080);
    acc(1'b0, 1'b1, 2'd0, 1'b1, 32'h21, 32'h0, "T3 lb", o);
    check("T3 lb const", o, 32'hFFFF_FF80);
    acc(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0, "T3 lw", o);
    check("T3 lw const", o, 32'h0000_8000);
    acc(1'b1, 1'b0, 2'd1, 1'b0, 32'h22, 32'h0000_1234, "T3 sh", o);
    acc(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0, "T3 lw2", o);
    check("T3 lw2 const", o, 32'h1234_8000);

    // T4: misaligned store leaves memory alone, first error sticks.
    acc(1'b1, 1'b0, 2'd2, 1'b0, 32'h31, 32'h1111_1111, "T4 sw mis", o);
    acc(1'b0, 1'b1, 2'd2, 1'b0, 32'h30, 32'h0, "T4 lw30", o);
    check("T4 lw30 const", o, 32'h0);
    check_err("T4a");
    check("T4 erraddr const", ErrAddr, 32'h31);
    acc(1'b0, 1'b1, 2'd1, 1'b1, 32'h43, 32'h0, "T4 lh mis", o);
    check("T4 lh const", o, 32'h0);
    check("T4 erraddr keep", ErrAddr, 32'h31);

    // T5: same-cycle read and write of one word.
    acc(1'b1, 1'b0, 2'd2, 1'b0, 32'h50, 32'hAAAA_0000, "T5 init", o);
    acc(1'b1, 1'b1, 2'd2, 1'b0, 32'h50, 32'h0000_5555, "T5 rw", o);
    check("T5 rw const", o, 32'hAAAA_0000);
    acc(1'b0, 1'b1, 2'd2, 1'b0, 32'h50, 32'h0, "T5 next", o);
    check("T5 next const", o, 32'h0000_5555);

    // Randomized traffic from a fresh reset so first-error capture is exercised too.
    do_reset();
    sweep_check("rand", 1'b0);
    for (int k = 0; k < 400; k++) begin
      wr = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      ad = (k < 200) ? ((32'($urandom_range(0, 255))) & ~(32'(nbytes(sz) - 1))) : $urandom;
      if (k % 50 == 49 && $urandom_range(0, 1) == 1) ad = ad | 32'h1;
      acc(wr, rd, sz, sg, ad, $urandom, $sformatf("rand%0d", k), o);
      check_err($sformatf("rand%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
